// File: rtl/ahb_slave_i2c_if_if.sv
// AHB bus bundle between the bridge's AHB master and the I2C-side responder.
// Carries the address/control, write data, HREADY handshake and the
// response/read data.
//   master : drives select, address, control, hwdata and bus-level hready_in
//   slave  : drives hready_out, hresp, hrdata
interface ahb_slave_i2c_if_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_slave_i2c_if.sv
// AHB responder for the AHB-to-I2C bridge. Decodes four word registers:
//   0x0 CTRL   (rw)  byte handed to the I2C core on ctrl
//   0x4 STATUS (r, write-1-to-clear overrun)
//         [0] rx_valid [1] overrun [2] tx_full [3] tx_empty [7:4] fifo_count
//   0x8 TXDATA (w)   pushes hwdata[7:0] into the TX FIFO
//   0xC RXDATA (r)   last byte from the I2C core, read clears rx_valid
// Ports:
//   Hclk, Hreset : clock, synchronous active-high reset
//   bus          : AHB slave modport (select, address, control, data, HREADY, HRESP)
//   ctrl         : CTRL register contents
//   tx_data      : registered head of the TX FIFO, tx_empty when no entries
//   tx_pop       : I2C core consumes the head byte (ignored when empty)
//   rx_wr/rx_byte: I2C core delivers a received byte
// Writes to a full TX FIFO stall the data phase; illegal accesses get the
// two-cycle ERROR response and touch nothing.
module ahb_slave_i2c_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  Hclk,
  input  logic                  Hreset,
  ahb_slave_i2c_if_if.slave     bus,
  output logic [7:0]            ctrl,
  output logic [7:0]            tx_data,
  output logic                  tx_empty,
  input  logic                  tx_pop,
  input  logic                  rx_wr,
  input  logic [7:0]            rx_byte
);

  localparam int PTR_W = CNT_W - 1;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_RXDATA = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT_FULL,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       off_q, off_d;
  logic             wr_q, wr_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       rx_reg_q, rx_reg_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;

  logic             ready;
  logic             resp;
  logic             full;
  logic             empty;
  logic             accept;
  logic             legal;
  logic             wr_commit;
  logic             push;
  logic             pop;
  logic             rx_read;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [31:0]      status_rd;
  logic             unused_bits;

  assign unused_bits = ^{bus.hwdata[31:8], bus.htrans[0]};

  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);

  // Data-phase handshake is a function of the state only; a TXDATA write
  // stalls on the registered fullness, so a pop in the same cycle does not
  // release it until the following cycle.
  always_comb begin
    ready = 1'b1;
    resp  = 1'b0;
    case (state_q)
      S_DATA:      ready = !(wr_q && (off_q == OFF_TXDATA) && full);
      S_WAIT_FULL: ready = !full;
      S_ERR1: begin
        ready = 1'b0;
        resp  = 1'b1;
      end
      S_ERR2:      resp  = 1'b1;
      default: ;
    endcase
  end

  // Address-phase decode. Only a phase boundary (ready high) can take a new
  // address; ERR1 never does.
  always_comb begin
    accept = bus.hsel && bus.hready_in && bus.htrans[1] && ready;
    legal  = (bus.haddr[31:4] == '0) && (bus.haddr[1:0] == 2'b00) &&
             (bus.hsize == 3'b010);
    case (bus.haddr[3:2])
      OFF_TXDATA: legal = legal && bus.hwrite;
      OFF_RXDATA: legal = legal && !bus.hwrite;
      default: ;
    endcase
    wr_commit = ready && wr_q && ((state_q == S_DATA) || (state_q == S_WAIT_FULL));
    push      = wr_commit && (off_q == OFF_TXDATA);
    pop       = tx_pop && !empty;
    rx_read   = accept && legal && !bus.hwrite && (bus.haddr[3:2] == OFF_RXDATA);
  end

  // TX FIFO. The head output is registered, so it is recomputed from the
  // post-edge read pointer; a push into an (effectively) empty FIFO bypasses
  // the memory and becomes the head directly.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = bus.hwdata[7:0];
    wptr_d        = wptr_q + PTR_W'(push);
    rptr_d        = rptr_q + PTR_W'(pop);
    cnt_after_pop = cnt_q - CNT_W'(pop);
    cnt_d         = cnt_after_pop + CNT_W'(push);
    tx_data_d     = tx_data_q;
    if (push && (cnt_after_pop == '0)) tx_data_d = bus.hwdata[7:0];
    else if (cnt_after_pop != '0)      tx_data_d = mem_q[rptr_d];
  end

  // Register file and RX path. Set beats clear for overrun, and a fresh byte
  // beats the read-clear of rx_valid.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_commit && (off_q == OFF_CTRL)) ctrl_d = bus.hwdata[7:0];
    overrun_d = overrun_q;
    if (wr_commit && (off_q == OFF_STATUS) && bus.hwdata[1]) overrun_d = 1'b0;
    if (rx_wr && rx_valid_q) overrun_d = 1'b1;
    rx_valid_d = rx_valid_q;
    if (rx_read) rx_valid_d = 1'b0;
    if (rx_wr)   rx_valid_d = 1'b1;
    rx_reg_d = rx_wr ? rx_byte : rx_reg_q;
    // Reads sample the post-edge view so a back-to-back read sees the write
    // (or FIFO push) completing at the same edge.
    status_rd = {24'b0, 4'(cnt_d), (cnt_d == '0), (cnt_d == CNT_W'(FIFO_DEPTH)),
                 overrun_d, rx_valid_d};
  end

  // Transfer FSM and read-data capture.
  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    wr_d     = wr_q;
    hrdata_d = hrdata_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (!ready) begin
      state_d = S_WAIT_FULL;
    end else begin
      hrdata_d = '0;
      if (accept) begin
        off_d   = bus.haddr[3:2];
        wr_d    = bus.hwrite;
        state_d = legal ? S_DATA : S_ERR1;
        if (legal && !bus.hwrite) begin
          case (bus.haddr[3:2])
            OFF_CTRL:   hrdata_d = {24'b0, ctrl_d};
            OFF_STATUS: hrdata_d = status_rd;
            OFF_RXDATA: hrdata_d = {24'b0, rx_reg_q};
            default:    hrdata_d = '0;
          endcase
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q    <= S_IDLE;
      hrdata_q   <= '0;
      ctrl_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hrdata_q   <= hrdata_d;
      ctrl_q     <= ctrl_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge Hclk) begin
    off_q    <= off_d;
    wr_q     <= wr_d;
    rx_reg_q <= rx_reg_d;
    mem_q    <= mem_d;
  end

  assign bus.hready_out = ready;
  assign bus.hresp      = resp;
  assign bus.hrdata     = hrdata_q;
  assign ctrl           = ctrl_q;
  assign tx_data        = tx_data_q;
  assign tx_empty       = empty;

endmodule

// File: tb/tb_ahb_slave_i2c_if.sv
module tb_ahb_slave_i2c_if;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ctrl;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_pop;
  logic       rx_wr;
  logic [7:0] rx_byte;

  int checks = 0;
  int errors = 0;

  vec_t       vq[$];
  exp_t       sb[$];
  logic [7:0] tx_model[$];

  ahb_slave_i2c_if_if bus();
  assign bus.hready_in = bus.hready_out;

  ahb_slave_i2c_if #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .Hclk    (clk),
    .Hreset  (rst),
    .bus     (bus),
    .ctrl    (ctrl),
    .tx_data (tx_data),
    .tx_empty(tx_empty),
    .tx_pop  (tx_pop),
    .rx_wr   (rx_wr),
    .rx_byte (rx_byte)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                              input logic [31:0] wd, input logic [31:0] rd, input logic e);
    vec_t v;
    v.addr = a; v.wr = w; v.size = s; v.wdata = wd; v.exp_rdata = rd; v.exp_err = e;
    return v;
  endfunction

  task automatic bus_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
  endtask

  task automatic check_tx(input string nm);
    if (tx_model.size() == 0) begin
      check({nm, "_empty"}, {31'b0, tx_empty}, 32'd1);
    end else begin
      check({nm, "_empty"}, {31'b0, tx_empty}, 32'd0);
      check({nm, "_head"}, {24'b0, tx_data}, {24'b0, tx_model[0]});
    end
  endtask

  // Issues everything in vq back-to-back. Expected responses go into the
  // scoreboard at the accepting edge and are compared when the data phase ends.
  // Entered and left at posedge+1.
  task automatic run_bus();
    vec_t cur;
    exp_t e;
    bit   dp    = 1'b0;
    int   waits = 0;
    int   cyc   = 0;
    while ((vq.size() > 0 || dp) && cyc < 200) begin
      if (vq.size() > 0) begin
        bus.hsel   = 1'b1;
        bus.haddr  = vq[0].addr;
        bus.htrans = 2'b10;
        bus.hwrite = vq[0].wr;
        bus.hsize  = vq[0].size;
      end else begin
        bus_idle();
      end
      if (dp) bus.hwdata = cur.wdata;
      @(negedge clk);
      if (dp && !bus.hready_out) begin
        waits++;
        if (cur.exp_err) check($sformatf("err1_hresp@%0h", cur.addr), {31'b0, bus.hresp}, 32'd1);
      end
      if (bus.hready_out) begin
        if (dp) begin
          e = sb.pop_front();
          check($sformatf("hresp@%0h", e.addr), {31'b0, bus.hresp}, {31'b0, e.err});
          check($sformatf("hrdata@%0h", e.addr), bus.hrdata, e.rdata);
          check($sformatf("waits@%0h", e.addr), waits, e.err ? 32'd1 : 32'd0);
          if (!e.err && cur.wr && cur.addr[3:0] == 4'h8) tx_model.push_back(cur.wdata[7:0]);
          dp = 1'b0;
        end
        if (vq.size() > 0) begin
          cur     = vq.pop_front();
          e.rdata = cur.exp_rdata;
          e.err   = cur.exp_err;
          e.addr  = cur.addr;
          sb.push_back(e);
          dp    = 1'b1;
          waits = 0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("bus_timeout", {31'b0, (dp || vq.size() > 0)}, 32'd0);
    vq.delete();
    sb.delete();
    bus_idle();
  endtask

  // Address phase of a TXDATA write, then its data phase against a full FIFO.
  task automatic start_stalled_write(input logic [7:0] b);
    bus.hsel = 1'b1; bus.haddr = 32'h8; bus.htrans = 2'b10;
    bus.hwrite = 1'b1; bus.hsize = 3'b010;
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = {24'b0, b};
    @(negedge clk);
    check("stall_ready", {31'b0, bus.hready_out}, 32'd0);
    check("stall_hresp", {31'b0, bus.hresp}, 32'd0);
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, "_ready"}, {31'b0, bus.hready_out}, 32'd1);
    check({nm, "_hresp"}, {31'b0, bus.hresp}, 32'd0);
    check({nm, "_hrdata"}, bus.hrdata, 32'd0);
    check({nm, "_ctrl"}, {24'b0, ctrl}, 32'd0);
    check({nm, "_empty"}, {31'b0, tx_empty}, 32'd1);
    check({nm, "_txdata"}, {24'b0, tx_data}, 32'd0);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(32'h4,  1'b0, 3'b010, 32'h0,  32'h8,  1'b0); // STATUS after reset
    tbl[1]  = mk(32'h0,  1'b1, 3'b010, 32'hA5, 32'h0,  1'b0); // CTRL write
    tbl[2]  = mk(32'h0,  1'b0, 3'b010, 32'h0,  32'hA5, 1'b0); // back-to-back CTRL read
    tbl[3]  = mk(32'h8,  1'b1, 3'b010, 32'h11, 32'h0,  1'b0);
    tbl[4]  = mk(32'h8,  1'b1, 3'b010, 32'h12, 32'h0,  1'b0);
    tbl[5]  = mk(32'h8,  1'b1, 3'b010, 32'h13, 32'h0,  1'b0);
    tbl[6]  = mk(32'h8,  1'b1, 3'b010, 32'h14, 32'h0,  1'b0);
    tbl[7]  = mk(32'h4,  1'b0, 3'b010, 32'h0,  32'h44, 1'b0); // count 4, full
    tbl[8]  = mk(32'hC,  1'b1, 3'b010, 32'h99, 32'h0,  1'b1); // write RXDATA
    tbl[9]  = mk(32'h10, 1'b0, 3'b010, 32'h0,  32'h0,  1'b1); // offset 0x10
    tbl[10] = mk(32'h0,  1'b1, 3'b000, 32'hFF, 32'h0,  1'b1); // byte-size CTRL
    tbl[11] = mk(32'h8,  1'b0, 3'b010, 32'h0,  32'h0,  1'b1); // read TXDATA
    tbl[12] = mk(32'h1,  1'b0, 3'b010, 32'h0,  32'h0,  1'b1); // misaligned
    tbl[13] = mk(32'h0,  1'b0, 3'b010, 32'h0,  32'hA5, 1'b0); // CTRL untouched
    tbl[14] = mk(32'h4,  1'b0, 3'b010, 32'h0,  32'h44, 1'b0); // FIFO untouched

    rst = 1'b1; tx_pop = 1'b0; rx_wr = 1'b0; rx_byte = 8'h0;
    bus.haddr = '0; bus.hsize = 3'b010; bus.hwdata = '0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1;

    // ---- table-driven register, FIFO fill and illegal-access vectors
    for (int i = 0; i < 15; i++) vq.push_back(tbl[i]);
    run_bus();
    check("ctrl_out", {24'b0, ctrl}, 32'hA5);
    check_tx("fill");

    // ---- fifth TXDATA write stalls until a single pop frees a slot
    start_stalled_write(8'h15);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_hold", {31'b0, bus.hready_out}, 32'd0);
    check("stall_head", {24'b0, tx_data}, 32'h11);
    @(posedge clk); #1;
    tx_pop = 1'b1;
    @(negedge clk);
    check("stall_pop_cycle", {31'b0, bus.hready_out}, 32'd0);
    @(posedge clk); #1;
    tx_pop = 1'b0;
    void'(tx_model.pop_front());
    @(negedge clk);
    check("stall_release", {31'b0, bus.hready_out}, 32'd1);
    check("stall_head2", {24'b0, tx_data}, 32'h12);
    @(posedge clk); #1;
    tx_model.push_back(8'h15);
    check_tx("after_push");
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h44, 1'b0));
    run_bus();

    // ---- drain the FIFO, head must follow write order
    for (int i = 0; i < 4; i++) begin
      tx_pop = 1'b1;
      @(posedge clk); #1;
      tx_pop = 1'b0;
      void'(tx_model.pop_front());
      check_tx($sformatf("drain%0d", i));
    end
    tx_pop = 1'b1;                      // pop on empty is ignored
    @(posedge clk); #1;
    tx_pop = 1'b0;
    check_tx("pop_empty");

    // ---- RX path: single byte, then overrun, then W1C
    rx_wr = 1'b1; rx_byte = 8'h3C;
    @(posedge clk); #1;
    rx_wr = 1'b0;
    vq.push_back(mk(32'hC, 1'b0, 3'b010, 32'h0, 32'h3C, 1'b0));
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h08, 1'b0));
    run_bus();
    rx_wr = 1'b1; rx_byte = 8'h7E;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_wr = 1'b0;
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h0B, 1'b0));
    vq.push_back(mk(32'h4, 1'b1, 3'b010, 32'h2, 32'h0,  1'b0));
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h09, 1'b0));
    vq.push_back(mk(32'hC, 1'b0, 3'b010, 32'h0, 32'h7E, 1'b0));
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h08, 1'b0));
    run_bus();

    // ---- reset while stalled in WAIT_FULL
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(32'h8, 1'b1, 3'b010, 32'h20 + i, 32'h0, 1'b0));
    run_bus();
    check_tx("refill");
    start_stalled_write(8'h24);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_model.delete();
    @(negedge clk);
    check_reset_state("rst_wait");
    @(posedge clk); #1;
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h08, 1'b0));
    vq.push_back(mk(32'h0, 1'b1, 3'b010, 32'h5A, 32'h0, 1'b0));
    run_bus();
    check("ctrl_5a", {24'b0, ctrl}, 32'h5A);

    // ---- reset during ERR1
    bus.hsel = 1'b1; bus.haddr = 32'hC; bus.htrans = 2'b10;
    bus.hwrite = 1'b1; bus.hsize = 3'b010;
    @(posedge clk); #1;
    bus_idle();
    rst = 1'b1;
    @(negedge clk);
    check("err1_ready", {31'b0, bus.hready_out}, 32'd0);
    check("err1_hresp", {31'b0, bus.hresp}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst_err1");
    @(posedge clk); #1;
    vq.push_back(mk(32'h0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0));
    vq.push_back(mk(32'h4, 1'b0, 3'b010, 32'h0, 32'h08, 1'b0));
    run_bus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slave_i2c_if.md
Name: ahb_slave_i2c_if

Overview:
- AHB responder (slave) end of the AHB-to-I2C bridge. It accepts AHB transfers from the bridge's AHB master and decodes a 4-register map.
- Writes to TXDATA push bytes into a TX FIFO drained by the I2C core.
- The I2C core deposits received bytes into RXDATA.
- Inserts wait states when the TX FIFO is full and gives the two-cycle AHB ERROR response on illegal accesses.

Parameters:
- FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
- CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- Hclk  in  1  system clock; all logic on rising edge.
- Hreset  in  1  synchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  32  address; only [3:0] decoded.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hwdata  in  32  write data, valid in the data phase.
- hready_in  in  1  bus-level HREADY.
- hready_out  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  32  read data.
- ctrl  out  8  CTRL register contents, to the I2C core.
- tx_data  out  8  FIFO head byte.
- tx_empty  out  1  FIFO empty.
- tx_pop  in  1  I2C core consumes the head byte; ignored when empty.
- rx_wr  in  1  I2C core delivers a byte.
- rx_byte  in  8  received byte.

Behaviour:
- Interface: one clock, Hclk. Reset Hreset is synchronous and active-high; it takes effect on the rising Hclk edge where Hreset=1.
- Reset values:
  - hready_out=1, hresp=0, hrdata=0, ctrl=0.
  - FIFO flushed: tx_empty=1, tx_data=0.
  - rx_valid=0, overrun=0, FSM to IDLE.
  - A transfer in progress at reset is abandoned with no register side effect.
- Accept rule: an address phase is accepted at an edge where hsel=1, hready_in=1 and htrans[1]=1.
  - IDLE, BUSY or unselected transfers: OKAY, zero wait, no side effect.
  - On accept, latch the offset, hwrite and a legality flag.
- Legal transfer: haddr[1:0]=00, hsize=010, and one of the following:
  - offset 0x0 CTRL, read or write;
  - offset 0x4 STATUS, read, or write (write-1-to-clear);
  - offset 0x8 TXDATA, write only;
  - offset 0xC RXDATA, read only.
  - Anything else, or an offset of 0x10 and above, is illegal.
- Register map:
  - CTRL [7:0]: read/write.
  - STATUS: {22'b0, fifo_count[CNT_W-1:0] zero-extended in [9:2]..., overrun[1], rx_valid[0]} is superseded by the following fixed layout: [0] rx_valid, [1] overrun, [2] tx_full, [3] tx_empty, [7:4] fifo_count (zero-extended), remaining bits 0.
  - STATUS write: hwdata[1]=1 clears overrun.
  - TXDATA: push hwdata[7:0].
  - RXDATA: returns {24'b0, rx_reg}; the read clears rx_valid.
- FSM states: IDLE, DATA, WAIT_FULL, ERR1, ERR2.
  - IDLE: on accept, go to ERR1 if illegal, else DATA.
  - DATA: zero-wait data phase, hready_out=1, hresp=0.
    - Read: hrdata holds the value registered at the accept edge.
    - Write: performed at the DATA edge using hwdata.
    - TXDATA write with FIFO full (evaluated before any same-cycle pop): hready_out=0 in DATA, go to WAIT_FULL.
    - A new accept at the DATA edge is handled as from IDLE (back-to-back pipelining).
  - WAIT_FULL: hready_out=0 while full. In the first cycle with !full, hready_out=1 and the push completes at that edge. A pop and a stalled push in the same cycle: the pop frees space, and the push lands on the next edge.
  - ERR1: hready_out=0, hresp=1. Always go to ERR2.
  - ERR2: hready_out=1, hresp=1. The next accept is handled as from IDLE.
  - An illegal access never changes any register.
- FIFO:
  - Circular buffer with pointers wrapping modulo FIFO_DEPTH.
  - tx_data is the head entry, registered.
  - Push and pop in the same cycle with the FIFO non-empty and non-full: count unchanged.
- RX path:
  - rx_wr loads rx_reg and sets rx_valid.
  - rx_wr while rx_valid=1: overwrite rx_reg and set overrun (sticky).
  - rx_wr in the same cycle as an RXDATA read: the new byte wins and rx_valid stays 1.
  - overrun clear and a new overrun in the same cycle: set wins.
- hrdata is 0 for writes and for error responses.

Test Plan:
- Reset, then read STATUS (NONSEQ, addr 0x4, hsize 010) -> hrdata=0x00000008, OKAY, hready_out=1 with zero waits.
- Write CTRL=0xA5, then back-to-back read CTRL in the next address phase -> ctrl=0xA5 after the write data phase; the read returns 0x000000A5 with no wait state.
- Five writes of 0x11..0x15 to TXDATA with tx_pop=0 -> first four OKAY and STATUS fifo_count=4, tx_full=1. The fifth holds hready_out=0; pulse tx_pop once -> tx_data advances 0x11→0x12 and the fifth write completes on the following edge.
- Read offset 0xC after rx_wr with 0x3C, then rx_wr 0x7E twice without a read -> first read returns 0x3C and rx_valid=0; after the double rx_wr, STATUS=...overrun=1, rx_valid=1. Write STATUS with hwdata=0x2 -> overrun=0.
- Illegal accesses (write to RXDATA, read at offset 0x10, hsize 000 to CTRL) -> each gives ERR1 (hready_out=0, hresp=1) then ERR2 (hready_out=1, hresp=1); CTRL and FIFO unchanged.
- Assert Hreset during WAIT_FULL and during ERR1 -> next edge hready_out=1, hresp=0, tx_empty=1, ctrl=0, FSM IDLE.
